cnn_layer_accel_job_sequencer: RTL and testbench
================================================

CNN_LAYER_ACCEL_JOB_SEQUENCER -- requirements
Module: cnn_layer_accel_job_sequencer

Interface
REQ-001 Parameter C_TIMEOUT, default 4096: cycles allowed per wait state; 0 disables the timeout.
REQ-002 Parameter C_CNT_WIDTH, default 16: width of job_count.
REQ-003 clk_if  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 desc_valid  in  1  host job descriptor valid.
REQ-006 desc_ready  out  1  sequencer can accept a descriptor.
REQ-007 desc_params  in  128  job parameters for the quad.
REQ-008 desc_cfg_mask  in  4  config lanes to load before start.
REQ-009 desc_cfg_data  in  128  config word broadcast to the masked lanes.
REQ-010 config_valid  out  4  per-lane config valid to the quad.
REQ-011 config_accept  in  4  per-lane config accept from the quad.
REQ-012 config_data  out  128  config word.
REQ-013 job_start  out  1  job request to the quad.
REQ-014 job_accept  in  1  quad accepted the job.
REQ-015 job_parameters  out  128  latched desc_params.
REQ-016 job_fetch_request  in  1  quad requests input data.
REQ-017 job_fetch_ack  out  1  fetch acknowledge pulse.
REQ-018 job_fetch_complete  in  1  quad finished fetching.
REQ-019 job_complete  in  1  quad finished the job.
REQ-020 job_complete_ack  out  1  completion acknowledge pulse.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 done  out  1  one-cycle pulse per completed job.
REQ-023 timeout_err  out  1  sticky timeout flag.
REQ-024 job_count  out  C_CNT_WIDTH  completed-job counter.

Function
REQ-025 The FSM SHALL have states IDLE, CONFIG, START, FETCH, RUN and CMPL_ACK; all outputs SHALL be registered.
REQ-026 IDLE: desc_ready=1. On desc_valid&desc_ready, latch params, mask and cfg data, and clear timeout_err. Next state is CONFIG if the mask is nonzero, otherwise START.
REQ-027 CONFIG: config_valid SHALL equal the pending mask, and config_data SHALL hold the latched word.
REQ-028 In CONFIG, a lane's pending bit SHALL clear on the cycle after its config_valid&config_accept.
REQ-029 In CONFIG, lanes SHALL complete independently and in any order; accepts on unmasked lanes SHALL be ignored.
REQ-030 When the pending mask reaches 0, the next state SHALL be START; config_valid SHALL never re-assert for a lane already accepted.
REQ-031 START: job_start=1 with job_parameters stable. On job_accept, job_start SHALL drop the next cycle and the next state SHALL be FETCH.
REQ-032 FETCH: each job_fetch_request cycle SHALL produce a job_fetch_ack one-cycle pulse, one cycle later; back-to-back requests SHALL produce back-to-back acks.
REQ-033 FETCH: job_fetch_complete SHALL move the FSM to RUN. A request coincident with fetch_complete SHALL still be acked.
REQ-034 FETCH: job_complete SHALL move the FSM directly to CMPL_ACK and takes priority over fetch_complete.
REQ-035 RUN: job_complete SHALL move the FSM to CMPL_ACK; job_fetch_request in RUN SHALL still be acked.
REQ-036 CMPL_ACK: job_complete_ack=1 and done=1 for exactly one cycle, and job_count SHALL increment, wrapping at 2^C_CNT_WIDTH to 0. Next state is IDLE.
REQ-037 Latency: the job_start edge SHALL occur 1 cycle after the last config accept, or 1 cycle after descriptor accept when the mask is 0.
REQ-038 Latency: job_complete to job_complete_ack SHALL be 1 cycle.
REQ-039 Timeout counter: cleared on every state change; counts in START, FETCH and RUN.
REQ-040 When C_TIMEOUT≠0 and the counter reaches C_TIMEOUT-1, timeout_err SHALL set and the FSM SHALL return to IDLE.
REQ-041 On that timeout, job_start, config_valid and the ack outputs SHALL deassert the same cycle the state changes; done SHALL stay 0 and job_count SHALL be unchanged.
REQ-042 Inputs not expected in the current state SHALL be ignored; stray job_accept and job_complete in IDLE SHALL have no effect.

Reset
REQ-043 On rst low, asynchronously: state=IDLE; config_valid=0; job_start=0; job_fetch_ack=0; job_complete_ack=0; done=0; busy=0; timeout_err=0; job_count=0.
REQ-044 On rst low, asynchronously: config_data=0, job_parameters=0, desc_ready=0. desc_ready SHALL rise on the first clk_if edge after rst deasserts.
REQ-045 Reset mid-job SHALL abort with no ack pulses.

Verification
REQ-046 Mask 4'b1011 with accepts in order lane3, lane0, lane1 -> config_valid steps 1011→0011→0010→0000; job_start rises 1 cycle after the lane1 accept.
REQ-047 Mask 0, params 0xA5.. -> job_start the cycle after desc accept; job_parameters=0xA5..; fetch request, then fetch_complete, then job_complete -> one ack each, done=1 once, job_count=1.
REQ-048 Three back-to-back job_fetch_request cycles -> three consecutive job_fetch_ack pulses, each 1 cycle late.
REQ-049 C_TIMEOUT=8 with job_accept withheld -> timeout_err=1 after 8 START cycles, FSM in IDLE, job_count unchanged; the next descriptor clears timeout_err.
REQ-050 job_count at 0xFFFF plus one completed job -> job_count=0x0000.
REQ-051 rst asserted in RUN -> all outputs at reset values immediately; no job_complete_ack; desc_ready=1 after release.

Source files
------------

// File: rtl/cnn_layer_accel_job_sequencer.sv
// Job sequencer for a CNN layer quad: takes one host descriptor, loads the
// masked config lanes, then walks the quad through start/fetch/run/complete.

module cnn_layer_accel_job_sequencer_cfg_lane (
    input  logic clk_if,
    input  logic rst,
    input  logic load,
    input  logic load_val,
    input  logic accept,
    output logic pending
);
    // Only set by a descriptor load, so a lane never re-asserts after its accept.
    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst)        pending <= 1'b0;
        else if (load)   pending <= load_val;
        else if (accept) pending <= 1'b0;
    end
endmodule

module cnn_layer_accel_job_sequencer #(
    parameter int C_TIMEOUT   = 4096,
    parameter int C_CNT_WIDTH = 16
) (
    input  logic                   clk_if,
    input  logic                   rst,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [127:0]           desc_params,
    input  logic [3:0]             desc_cfg_mask,
    input  logic [127:0]           desc_cfg_data,
    output logic [3:0]             config_valid,
    input  logic [3:0]             config_accept,
    output logic [127:0]           config_data,
    output logic                   job_start,
    input  logic                   job_accept,
    output logic [127:0]           job_parameters,
    input  logic                   job_fetch_request,
    output logic                   job_fetch_ack,
    input  logic                   job_fetch_complete,
    input  logic                   job_complete,
    output logic                   job_complete_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [C_CNT_WIDTH-1:0] job_count
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 128;
    localparam int TW        = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
    localparam int TMO_LAST_I = (C_TIMEOUT == 0) ? 0 : C_TIMEOUT - 1;
    localparam logic [TW-1:0] TMO_LAST = TMO_LAST_I[TW-1:0];

    typedef enum logic [2:0] {IDLE, CONFIG, START, FETCH, RUN, CMPL_ACK} state_t;

    typedef struct packed {
        logic [VEC_W-1:0] params;
        logic [VEC_W-1:0] cfg;
    } job_desc_t;

    state_t              state_q, state_d;
    job_desc_t           desc_q;
    logic [NUM_LANES-1:0] pending;
    logic [TW-1:0]       tmo_cnt;
    logic                desc_fire, in_wait, fetch_phase, tmo_hit, cmpl_enter;
    logic [NUM_LANES-1:0] pend_left;

    assign desc_fire   = desc_valid & desc_ready;
    assign in_wait     = (state_q == START) || (state_q == FETCH) || (state_q == RUN);
    assign fetch_phase = (state_q == FETCH) || (state_q == RUN);
    assign tmo_hit     = (C_TIMEOUT != 0) && in_wait && (tmo_cnt == TMO_LAST);
    assign pend_left   = pending & ~config_accept;
    assign cmpl_enter  = (state_d == CMPL_ACK);

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            cnn_layer_accel_job_sequencer_cfg_lane u_lane (
                .clk_if   (clk_if),
                .rst      (rst),
                .load     (desc_fire),
                .load_val (desc_cfg_mask[i]),
                .accept   (config_accept[i]),
                .pending  (pending[i])
            );
        end
    endgenerate

    assign config_valid   = pending;
    assign config_data    = desc_q.cfg;
    assign job_parameters = desc_q.params;

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (desc_fire) state_d = (desc_cfg_mask != '0) ? CONFIG : START;
            CONFIG:   if (pend_left == '0) state_d = START;
            START:    if (job_accept) state_d = FETCH;
            FETCH: begin
                if (job_complete)            state_d = CMPL_ACK;
                else if (job_fetch_complete) state_d = RUN;
            end
            RUN:      if (job_complete) state_d = CMPL_ACK;
            CMPL_ACK: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // A stalled handshake abandons the job regardless of coincident inputs.
        if (tmo_hit) state_d = IDLE;
    end

    // Every output is a flop fed from the next state, so each one moves on
    // the same edge as the state it belongs to.
    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            desc_q           <= '0;
            desc_ready       <= 1'b0;
            busy             <= 1'b0;
            job_start        <= 1'b0;
            job_fetch_ack    <= 1'b0;
            job_complete_ack <= 1'b0;
            done             <= 1'b0;
            timeout_err      <= 1'b0;
            job_count        <= '0;
            tmo_cnt          <= '0;
        end else begin
            desc_ready       <= (state_d == IDLE);
            busy             <= (state_d != IDLE);
            job_start        <= (state_d == START);
            job_fetch_ack    <= job_fetch_request & fetch_phase & ~tmo_hit;
            job_complete_ack <= cmpl_enter;
            done             <= cmpl_enter;
            if (cmpl_enter) job_count <= job_count + 1'b1;
            if (desc_fire) begin
                desc_q      <= '{desc_params, desc_cfg_data};
                timeout_err <= 1'b0;
            end else if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
            tmo_cnt <= (state_d == state_q && in_wait) ? tmo_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_cnn_layer_accel_job_sequencer.sv
// Directed bench: stimulus queues expected output events with their cycle,
// a negedge monitor pops and compares every event the sequencer emits.

module tb_cnn_layer_accel_job_sequencer;
    localparam int EV_CFG = 0, EV_START = 1, EV_FACK = 2, EV_CACK = 3, EV_TMO = 4;

    typedef struct {
        int           kind;
        int           cyc;
        logic [127:0] data;
    } ev_t;

    logic         clk_if = 1'b0, rst = 1'b1;
    logic         desc_valid = 0, desc_ready;
    logic [127:0] desc_params = '0, desc_cfg_data = '0;
    logic [3:0]   desc_cfg_mask = '0;
    logic [3:0]   config_valid, config_accept = '0;
    logic [127:0] config_data, job_parameters;
    logic         job_start, job_accept = 0;
    logic         job_fetch_request = 0, job_fetch_ack, job_fetch_complete = 0;
    logic         job_complete = 0, job_complete_ack;
    logic         busy, done, timeout_err;
    logic [3:0]   job_count;

    int   cyc = 0, total = 0, bad = 0;
    ev_t  exp_q[$];
    logic [3:0] exp_cnt = 4'h0;
    logic [3:0] cv_prev = '0;
    logic       js_prev = 0, te_prev = 0;

    cnn_layer_accel_job_sequencer #(.C_TIMEOUT(8), .C_CNT_WIDTH(4)) dut (
        .clk_if(clk_if), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_params(desc_params), .desc_cfg_mask(desc_cfg_mask), .desc_cfg_data(desc_cfg_data),
        .config_valid(config_valid), .config_accept(config_accept), .config_data(config_data),
        .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
        .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
        .job_fetch_complete(job_fetch_complete),
        .job_complete(job_complete), .job_complete_ack(job_complete_ack),
        .busy(busy), .done(done), .timeout_err(timeout_err), .job_count(job_count)
    );

    always #5 clk_if = ~clk_if;
    always @(posedge clk_if) cyc <= cyc + 1;

    function automatic logic [127:0] mk_cack(input logic [3:0] c);
        return {122'b0, 1'b1, 1'b1, c};
    endfunction

    function automatic logic [127:0] mk_tmo(input logic [3:0] c);
        return {120'b0, 1'b0, 1'b0, 1'b1, 1'b0, c};
    endfunction

    task automatic push(input int kind, input logic [127:0] data);
        ev_t e;
        e.kind = kind; e.cyc = cyc; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic emit(input int kind, input logic [127:0] data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%h, none required", kind, cyc, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                bad++;
                $display("FAIL event: got kind=%0d cyc=%0d data=%h, required kind=%0d cyc=%0d data=%h",
                         kind, cyc, data, e.kind, e.cyc, e.data);
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    always @(negedge clk_if) begin
        if (rst) begin
            if (config_valid != cv_prev) emit(EV_CFG, {124'b0, config_valid});
            if (job_start && !js_prev) emit(EV_START, job_parameters);
            if (job_fetch_ack) emit(EV_FACK, '0);
            if (job_complete_ack || done)
                emit(EV_CACK, {122'b0, done, job_complete_ack, job_count});
            if (timeout_err && !te_prev)
                emit(EV_TMO, {120'b0, job_start, busy, desc_ready, done, job_count});
        end
        cv_prev = config_valid;
        js_prev = job_start;
        te_prev = timeout_err;
    end

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    task automatic send_desc(input logic [127:0] p, input logic [3:0] m, input logic [127:0] c);
        desc_params = p; desc_cfg_mask = m; desc_cfg_data = c; desc_valid = 1;
        tick();
        desc_valid = 0; desc_params = ~p; desc_cfg_data = ~c; desc_cfg_mask = ~m;
        if (m != 0) push(EV_CFG, {124'b0, m});
        else        push(EV_START, p);
    endtask

    task automatic do_accept();
        job_accept = 1;
        tick();
        job_accept = 0;
    endtask

    task automatic do_complete(input logic fc);
        job_complete = 1; job_fetch_complete = fc;
        tick();
        job_complete = 0; job_fetch_complete = 0;
        exp_cnt = exp_cnt + 1'b1;
        push(EV_CACK, mk_cack(exp_cnt));
        tick();
    endtask

    task automatic simple_job(input logic [127:0] p);
        send_desc(p, 4'b0000, ~p);
        do_accept();
        do_complete(1'b0);
    endtask

    initial begin
        logic [127:0] pa;
        ev_t e;
        pa = {16{8'hA5}};
        // reset state
        #2 rst = 0;
        #1;
        chk("rst_desc_ready", desc_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_job_count", job_count, 0);
        chk("rst_config_valid", config_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        #19 rst = 1;
        tick();
        chk("desc_ready_after_rst", desc_ready, 1);

        // mask 1011: accepts lane3, lane0 (+unmasked lane2), lane1
        send_desc(128'h1111_2222_3333_4444_5555_6666_7777_8888, 4'b1011, 128'hC0FFEE);
        chk("config_data", config_data, 128'hC0FFEE);
        config_accept = 4'b0100; tick();
        config_accept = 4'b1000; tick(); push(EV_CFG, 128'h3);
        config_accept = 4'b0101; tick(); push(EV_CFG, 128'h2);
        config_accept = 4'b0010; tick(); push(EV_CFG, 128'h0);
        push(EV_START, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        config_accept = 4'b0000;
        do_accept();
        do_complete(1'b0);

        // mask 0, A5 params, one fetch, fetch_complete, job_complete
        send_desc(pa, 4'b0000, 128'h5A);
        chk("job_parameters", job_parameters, pa);
        do_accept();
        job_fetch_request = 1; tick(); job_fetch_request = 0; push(EV_FACK, '0);
        job_fetch_complete = 1; tick(); job_fetch_complete = 0;
        do_complete(1'b0);
        chk("count_after_a5", job_count, 4'h2);

        // back-to-back requests, last one coincident with fetch_complete, one in RUN
        send_desc(128'h3, 4'b0000, 128'h0);
        do_accept();
        job_fetch_request = 1;
        tick(); push(EV_FACK, '0);
        tick(); push(EV_FACK, '0);
        job_fetch_complete = 1;
        tick(); push(EV_FACK, '0);
        job_fetch_complete = 0; job_fetch_request = 0;
        tick();
        job_fetch_request = 1; tick(); job_fetch_request = 0; push(EV_FACK, '0);
        do_complete(1'b0);

        // job_complete wins over fetch_complete in FETCH
        send_desc(128'h4, 4'b0000, 128'h0);
        do_accept();
        do_complete(1'b1);
        chk("busy_idle", busy, 0);

        // 7 cycles in START and 7 in FETCH: counter restarts on state change
        send_desc(128'h5, 4'b0000, 128'h0);
        repeat (6) tick();
        do_accept();
        repeat (6) tick();
        do_complete(1'b0);

        // START timeout
        send_desc(128'h6, 4'b0000, 128'h0);
        repeat (8) tick();
        push(EV_TMO, mk_tmo(exp_cnt));
        tick();
        chk("tmo_sticky", timeout_err, 1);
        chk("tmo_count", job_count, 4'h5);

        // stray job_accept/job_complete in IDLE
        job_accept = 1; job_complete = 1;
        repeat (2) tick();
        job_accept = 0; job_complete = 0;
        chk("stray_busy", busy, 0);
        chk("stray_ready", desc_ready, 1);

        // next descriptor clears the sticky flag
        send_desc(128'h7, 4'b0000, 128'h0);
        chk("tmo_cleared", timeout_err, 0);
        do_accept();
        do_complete(1'b0);

        // counter wrap
        for (int i = 0; i < 9; i++) simple_job(128'h100 + 128'(i));
        chk("count_max", job_count, 4'hF);
        simple_job(128'h200);
        chk("count_wrap", job_count, 4'h0);

        // reset while in RUN
        send_desc(128'hDEAD, 4'b0000, 128'hBEEF);
        do_accept();
        job_fetch_complete = 1; tick(); job_fetch_complete = 0;
        job_complete = 1;
        #2 rst = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_job_start", job_start, 0);
        chk("mid_rst_cack", job_complete_ack, 0);
        chk("mid_rst_params", job_parameters, 0);
        chk("mid_rst_cfg_data", config_data, 0);
        chk("mid_rst_desc_ready", desc_ready, 0);
        repeat (2) @(posedge clk_if);
        #2 job_complete = 0;
        #1 rst = 1;
        tick();
        chk("post_rst_ready", desc_ready, 1);
        chk("post_rst_count", job_count, 0);
        repeat (3) tick();

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++; bad++;
            $display("FAIL missing_event: got none, required kind=%0d cyc=%0d data=%h", e.kind, e.cyc, e.data);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
